par_circ_buffer: RTL and testbench
==================================

// Module: par_circ_buffer
// PURPOSE
//  Circular column buffer with PAR_WRITE-wide parallel push and PAR_READ-wide parallel pop.
//  Replaces standalone pointer-compare empty logic with one registered block that owns
//  storage, both pointers, an occupancy count and the empty/full status.
//  Sits between the producer and the PAR_READ-lane datapath consumer.
// PARAMETERS
//  DATA_WIDTH  16  bits per entry
//  COLUMNS     32  number of entries; need not be a power of 2; must be >= max(PAR_WRITE,PAR_READ)
//  PAR_WRITE   2   entries pushed per accepted write
//  PAR_READ    4   entries popped per accepted read
// PORTS
//  clk         in   1                      clock; all state updates on posedge
//  rst         in   1                      synchronous reset, active high
//  write_en    in   1                      push request
//  write_data  in   PAR_WRITE*DATA_WIDTH   lane k in bits [k*DATA_WIDTH +: DATA_WIDTH]; lane 0 is oldest
//  read_en     in   1                      pop request
//  read_data   out  PAR_READ*DATA_WIDTH    show-ahead window; lane k = entry at read_ptr+k (mod COLUMNS)
//  empty       out  1                      high when count < PAR_READ
//  full        out  1                      high when COLUMNS - count < PAR_WRITE
//  count       out  $clog2(COLUMNS+1)      number of valid entries
//  overflow    out  1                      sticky error flag; only with PAR_CIRC_BUFFER_ERR_EN
//  underflow   out  1                      sticky error flag; only with PAR_CIRC_BUFFER_ERR_EN
// BEHAVIOUR
//  - Reset: write_ptr=0, read_ptr=0, count=0, empty=1, full=0; flags cleared when present.
//    Storage is not cleared. rst overrides any same-cycle write_en or read_en.
//  - Write accepted iff write_en && !full. Entry write_ptr+k (mod COLUMNS) gets lane k.
//    write_ptr advances by PAR_WRITE (mod COLUMNS). write_en while full is dropped with no state change.
//  - Read accepted iff read_en && !empty. read_ptr advances by PAR_READ (mod COLUMNS).
//    read_en while empty is dropped.
//  - read_data is combinational from storage and read_ptr (zero latency).
//    Its contents are valid only while empty=0.
//  - Written data is visible on read_data and in count one cycle after acceptance.
//  - Simultaneous accept: both ptrs update.
//    count_next = count + PAR_WRITE*wacc - PAR_READ*racc.
//    empty/full decisions use the pre-edge count.
//  - Wrap rule: ptr_next = (ptr+N >= COLUMNS) ? ptr+N-COLUMNS : ptr+N.
//    Compute in $clog2(COLUMNS)+1 bits. No modulo operator.
//    The same rule applies per lane for storage addressing.
//  - Windows straddling entry COLUMNS-1 -> 0 are legal for both read and write.
//  - empty, full and count are derived combinationally from the count register; no extra latency.
// CONFIGURATION
//  - PAR_CIRC_BUFFER_ERR_EN defined:
//    - overflow sets on write_en && full; underflow sets on read_en && empty.
//    - Both flags are sticky until rst.
//  - PAR_CIRC_BUFFER_ERR_EN undefined: overflow/underflow ports and logic are absent.
//    Dropped requests are silent.
// STRUCTURE
//  - Package par_circ_buffer_pkg holds:
//    - the PTR_W / CNT_W width functions of COLUMNS;
//    - the wrap_add(ptr, inc, COLUMNS) function.
//  - One sub-module, circ_ptr_wrap: registered pointer with synchronous clear.
//    It is parameterised by COLUMNS and STEP and has an adv input.
//    Instantiated twice: STEP=PAR_WRITE and STEP=PAR_READ.
//  - Storage is a flat reg array; write lanes and read lanes are generate loops.
// TESTING  (defaults; DATA_WIDTH=16, COLUMNS=32, PAR_WRITE=2, PAR_READ=4)
//  1. Reset with rst=1 for 2 clocks -> empty=1, full=0, count=0; flags 0 when enabled.
//  2. Write {0x0B,0x0A} then {0x0D,0x0C}, no reads.
//     -> count=2 then 4; empty falls after 2nd write.
//     -> read_data lanes 0..3 = 0x0A,0x0B,0x0C,0x0D.
//  3. 16 consecutive writes -> count=32, full=1.
//     17th write_en -> count stays 32, write_ptr unchanged; overflow=1 when ERR_EN.
//  4. Write 14 times, read 7 times (count=0, ptrs=28).
//     Write 4 pairs 0x100..0x107, covering entries 28..31 and 0..3.
//     -> read lanes 0x100..0x103 from 28..31; next read gives 0x104..0x107 from 0..3.
//  5. At count=4, drive write_en and read_en in the same cycle.
//     -> both accepted, count=2, empty=1.
//     -> the pair just written appears at read_data lanes 0..1.
//  6. At count=12, assert rst together with write_en and read_en.
//     -> next cycle count=0, ptrs=0, empty=1.
//     Random push/pop run of 10k cycles against a queue model: count and read_data match every cycle.

Source files
------------

// File: rtl/par_circ_buffer_pkg.sv
// Shared widths and wrap arithmetic for par_circ_buffer and its pointer sub-module.
package par_circ_buffer_pkg;

    // Pointer register width; at least one bit even for a single-entry buffer.
    function automatic int unsigned PTR_W(input int unsigned columns);
        return (columns > 1) ? $clog2(columns) : 1;
    endfunction

    function automatic int unsigned CNT_W(input int unsigned columns);
        return $clog2(columns + 1);
    endfunction

    // Wrap by a single conditional subtract; valid while ptr < columns and inc <= columns.
    function automatic int unsigned wrap_add(input int unsigned ptr, input int unsigned inc,
                                             input int unsigned columns);
        int unsigned sum;
        sum = ptr + inc;
        return (sum >= columns) ? sum - columns : sum;
    endfunction

endpackage

// File: rtl/circ_ptr_wrap.sv
// Registered circular pointer that advances by STEP (mod COLUMNS) on adv; cleared by rst.
module circ_ptr_wrap
    import par_circ_buffer_pkg::*;
#(
    parameter int unsigned COLUMNS = 32,
    parameter int unsigned STEP    = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        adv,
    output logic [PTR_W(COLUMNS)-1:0]   ptr
);

    localparam int unsigned PW = PTR_W(COLUMNS);

    logic [PW-1:0] ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (adv) begin
            ptr_d = PW'(wrap_add(32'(ptr_q), STEP, COLUMNS));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/par_circ_buffer.sv
// Circular column buffer: PAR_WRITE-wide push, PAR_READ-wide show-ahead pop.
// Optional sticky overflow/underflow flags when PAR_CIRC_BUFFER_ERR_EN is defined.
module par_circ_buffer
    import par_circ_buffer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned COLUMNS    = 32,
    parameter int unsigned PAR_WRITE  = 2,
    parameter int unsigned PAR_READ   = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             write_en,
    input  logic [PAR_WRITE*DATA_WIDTH-1:0]  write_data,
    input  logic                             read_en,
    output logic [PAR_READ*DATA_WIDTH-1:0]   read_data,
    output logic                             empty,
    output logic                             full,
`ifdef PAR_CIRC_BUFFER_ERR_EN
    output logic [CNT_W(COLUMNS)-1:0]        count,
    output logic                             overflow,
    output logic                             underflow
`else
    output logic [CNT_W(COLUMNS)-1:0]        count
`endif
);

    localparam int unsigned PW = PTR_W(COLUMNS);
    localparam int unsigned CW = CNT_W(COLUMNS);

    logic [DATA_WIDTH-1:0] mem [COLUMNS];
    logic [PW-1:0]         write_ptr, read_ptr;
    logic [CW-1:0]         count_q, count_d;
    logic                  wacc, racc;
    logic [PW-1:0]         waddr [PAR_WRITE];
    logic [PW-1:0]         raddr [PAR_READ];

    // Status comes straight from the count register so it tracks count with no lag.
    assign empty = count_q < CW'(PAR_READ);
    assign full  = count_q > CW'(COLUMNS - PAR_WRITE);
    assign count = count_q;

    assign wacc = write_en && !full;
    assign racc = read_en && !empty;

    always_comb begin
        count_d = count_q;
        if (wacc) begin
            count_d = count_d + CW'(PAR_WRITE);
        end
        if (racc) begin
            count_d = count_d - CW'(PAR_READ);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    circ_ptr_wrap #(
        .COLUMNS (COLUMNS),
        .STEP    (PAR_WRITE)
    ) u_write_ptr (
        .clk (clk),
        .rst (rst),
        .adv (wacc),
        .ptr (write_ptr)
    );

    circ_ptr_wrap #(
        .COLUMNS (COLUMNS),
        .STEP    (PAR_READ)
    ) u_read_ptr (
        .clk (clk),
        .rst (rst),
        .adv (racc),
        .ptr (read_ptr)
    );

    for (genvar k = 0; k < PAR_WRITE; k++) begin : g_wlane
        assign waddr[k] = PW'(wrap_add(32'(write_ptr), k, COLUMNS));
    end

    for (genvar k = 0; k < PAR_READ; k++) begin : g_rlane
        assign raddr[k] = PW'(wrap_add(32'(read_ptr), k, COLUMNS));
        assign read_data[k*DATA_WIDTH +: DATA_WIDTH] = mem[raddr[k]];
    end

    // Storage is never cleared; rst only suppresses a same-cycle write.
    always_ff @(posedge clk) begin
        if (wacc && !rst) begin
            for (int k = 0; k < PAR_WRITE; k++) begin
                mem[waddr[k]] <= write_data[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

`ifdef PAR_CIRC_BUFFER_ERR_EN
    logic overflow_q, underflow_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (write_en && full) begin
                overflow_q <= 1'b1;
            end
            if (read_en && empty) begin
                underflow_q <= 1'b1;
            end
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_par_circ_buffer.sv
// Directed and random checks of par_circ_buffer against a queue-based reference model.
module tb_par_circ_buffer;

    localparam int unsigned DATA_WIDTH = 16;
    localparam int unsigned COLUMNS    = 32;
    localparam int unsigned PAR_WRITE  = 2;
    localparam int unsigned PAR_READ   = 4;
    localparam int unsigned CW         = $clog2(COLUMNS + 1);

    logic                            clk = 1'b0;
    logic                            rst;
    logic                            write_en;
    logic [PAR_WRITE*DATA_WIDTH-1:0] write_data;
    logic                            read_en;
    logic [PAR_READ*DATA_WIDTH-1:0]  read_data;
    logic                            empty;
    logic                            full;
    logic [CW-1:0]                   count;
`ifdef PAR_CIRC_BUFFER_ERR_EN
    logic                            overflow;
    logic                            underflow;
`endif

    always #5 clk = ~clk;

    par_circ_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .COLUMNS    (COLUMNS),
        .PAR_WRITE  (PAR_WRITE),
        .PAR_READ   (PAR_READ)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .write_en   (write_en),
        .write_data (write_data),
        .read_en    (read_en),
        .read_data  (read_data),
        .empty      (empty),
        .full       (full),
`ifdef PAR_CIRC_BUFFER_ERR_EN
        .count      (count),
        .overflow   (overflow),
        .underflow  (underflow)
`else
        .count      (count)
`endif
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: FIFO contents, oldest first, plus sticky flags.
    logic [DATA_WIDTH-1:0] q[$];
    bit                    m_ovf;
    bit                    m_unf;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [PAR_WRITE*DATA_WIDTH-1:0] pair(input logic [15:0] a,
                                                             input logic [15:0] b);
        return {b, a};
    endfunction

    function automatic void model_update(input bit rs, input bit we,
                                         input logic [PAR_WRITE*DATA_WIDTH-1:0] wd,
                                         input bit re);
        bit can_w, can_r;
        can_w = (COLUMNS - q.size()) >= PAR_WRITE;
        can_r = q.size() >= PAR_READ;
        if (rs) begin
            q.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            if (we && !can_w) m_ovf = 1'b1;
            if (re && !can_r) m_unf = 1'b1;
            if (re && can_r) begin
                for (int k = 0; k < PAR_READ; k++) void'(q.pop_front());
            end
            if (we && can_w) begin
                for (int k = 0; k < PAR_WRITE; k++) q.push_back(wd[k*DATA_WIDTH +: DATA_WIDTH]);
            end
        end
    endfunction

    task automatic check_model();
        check("count", 32'(count), q.size());
        check("empty", 32'(empty), 32'(q.size() < PAR_READ));
        check("full", 32'(full), 32'((COLUMNS - q.size()) < PAR_WRITE));
`ifdef PAR_CIRC_BUFFER_ERR_EN
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("underflow", 32'(underflow), 32'(m_unf));
`endif
        if (q.size() >= PAR_READ) begin
            for (int k = 0; k < PAR_READ; k++) begin
                check($sformatf("lane%0d", k), 32'(read_data[k*DATA_WIDTH +: DATA_WIDTH]),
                      32'(q[k]));
            end
        end
    endtask

    // Called at a negedge: drive, clock, update model, then check at the next negedge.
    task automatic cycle(input bit rs, input bit we,
                         input logic [PAR_WRITE*DATA_WIDTH-1:0] wd, input bit re);
        rst        = rs;
        write_en   = we;
        write_data = wd;
        read_en    = re;
        @(posedge clk);
        model_update(rs, we, wd, re);
        @(negedge clk);
        rst      = 1'b0;
        write_en = 1'b0;
        read_en  = 1'b0;
        check_model();
    endtask

    task automatic push(input logic [PAR_WRITE*DATA_WIDTH-1:0] wd);
        cycle(1'b0, 1'b1, wd, 1'b0);
    endtask

    task automatic pop();
        cycle(1'b0, 1'b0, '0, 1'b1);
    endtask

    task automatic lane_is(input string tag, input int k, input logic [15:0] exp);
        check($sformatf("%s_lane%0d", tag, k), 32'(read_data[k*DATA_WIDTH +: DATA_WIDTH]),
              32'(exp));
    endtask

    initial begin
        int wp, rp;
        bit rs, we, re;
        rst        = 1'b1;
        write_en   = 1'b0;
        read_en    = 1'b0;
        write_data = '0;
        @(negedge clk);

        // Reset held for two clocks.
        cycle(1'b1, 1'b0, '0, 1'b0);
        cycle(1'b1, 1'b0, '0, 1'b0);
        check("rst_count", 32'(count), 0);
        check("rst_empty", 32'(empty), 1);
        check("rst_full", 32'(full), 0);

        // Two pairs, lane 0 oldest.
        push(pair(16'h000A, 16'h000B));
        check("t2_count1", 32'(count), 2);
        check("t2_empty1", 32'(empty), 1);
        push(pair(16'h000C, 16'h000D));
        check("t2_count2", 32'(count), 4);
        check("t2_empty2", 32'(empty), 0);
        lane_is("t2", 0, 16'h000A);
        lane_is("t2", 1, 16'h000B);
        lane_is("t2", 2, 16'h000C);
        lane_is("t2", 3, 16'h000D);

        // Fill to full, then one dropped write.
        cycle(1'b1, 1'b0, '0, 1'b0);
        for (int i = 0; i < 16; i++) push(pair(16'(2 * i), 16'(2 * i + 1)));
        check("t3_count", 32'(count), 32);
        check("t3_full", 32'(full), 1);
        push(pair(16'hDEAD, 16'hBEEF));
        check("t3_count_ovf", 32'(count), 32);
`ifdef PAR_CIRC_BUFFER_ERR_EN
        check("t3_overflow", 32'(overflow), 1);
`endif
        pop();
        push(pair(16'h0055, 16'h0066));
        for (int i = 0; i < 7; i++) pop();

        // Window straddling entry 31 -> 0.
        cycle(1'b1, 1'b0, '0, 1'b0);
        for (int i = 0; i < 14; i++) push(pair(16'($urandom), 16'($urandom)));
        for (int i = 0; i < 7; i++) pop();
        check("t4_count0", 32'(count), 0);
        push(pair(16'h0100, 16'h0101));
        push(pair(16'h0102, 16'h0103));
        lane_is("t4a", 0, 16'h0100);
        lane_is("t4a", 3, 16'h0103);
        push(pair(16'h0104, 16'h0105));
        push(pair(16'h0106, 16'h0107));
        check("t4_count8", 32'(count), 8);
        pop();
        lane_is("t4b", 0, 16'h0104);
        lane_is("t4b", 1, 16'h0105);
        lane_is("t4b", 2, 16'h0106);
        lane_is("t4b", 3, 16'h0107);

        // Simultaneous push and pop at count 4.
        check("t5_count4", 32'(count), 4);
        cycle(1'b0, 1'b1, pair(16'h0200, 16'h0201), 1'b1);
        check("t5_count", 32'(count), 2);
        check("t5_empty", 32'(empty), 1);
        lane_is("t5", 0, 16'h0200);
        lane_is("t5", 1, 16'h0201);
        pop();
        check("t5_drop_count", 32'(count), 2);
`ifdef PAR_CIRC_BUFFER_ERR_EN
        check("t5_underflow", 32'(underflow), 1);
`endif

        // Reset beats same-cycle push and pop.
        for (int i = 0; i < 5; i++) push(pair(16'($urandom), 16'($urandom)));
        check("t6_count12", 32'(count), 12);
        cycle(1'b1, 1'b1, pair(16'h0300, 16'h0301), 1'b1);
        check("t6_count", 32'(count), 0);
        check("t6_empty", 32'(empty), 1);
        push(pair(16'h0400, 16'h0401));
        push(pair(16'h0402, 16'h0403));
        lane_is("t6", 0, 16'h0400);
        lane_is("t6", 3, 16'h0403);

        // Random push/pop with shifting bias so both full and empty get exercised.
        wp = 50;
        rp = 50;
        for (int i = 0; i < 10000; i++) begin
            if (i % 500 == 0) begin
                wp = $urandom_range(15, 90);
                rp = $urandom_range(15, 90);
            end
            rs = ($urandom_range(0, 1999) == 0);
            we = ($urandom_range(0, 99) < wp);
            re = ($urandom_range(0, 99) < rp);
            cycle(rs, we, PAR_WRITE*DATA_WIDTH'($urandom), re);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
